// File: rtl/ball_motion_ctrl.sv
// Per-frame ball motion sequencer: tilt -> velocity -> proposed move -> collision handshake -> commit.
// Optional BALL_BOUNCE_EN: a wall-hit or blocked axis reverses and halves velocity instead of zeroing it.
module ball_motion_ctrl #(
   parameter int X_W         = 10,
   parameter int Y_W         = 9,
   parameter int VEL_W       = 5,
   parameter int VMAX        = 8,
   parameter int ACCEL       = 1,
   parameter int XMIN        = 0,
   parameter int XMAX        = 639,
   parameter int YMIN        = 0,
   parameter int YMAX        = 479,
   parameter int START_X     = 320,
   parameter int START_Y     = 240,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    frame_tick,
   input  logic [3:0]              tilt,
   output logic                    chk_req,
   output logic [X_W-1:0]          chk_x,
   output logic [Y_W-1:0]          chk_y,
   input  logic                    chk_ack,
   input  logic                    blk_x,
   input  logic                    blk_y,
   output logic [X_W-1:0]          pos_x,
   output logic [Y_W-1:0]          pos_y,
   output logic signed [VEL_W-1:0] vel_x,
   output logic signed [VEL_W-1:0] vel_y,
   output logic                    busy,
   output logic                    upd_done,
   output logic                    overrun
);

   typedef enum logic [2:0] {IDLE, SAMPLE, PROPOSE, WAIT, COMMIT} state_t;

   localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
   localparam logic signed [VEL_W:0] VMAX_W  = (VEL_W+1)'(VMAX);
   localparam logic signed [VEL_W:0] ACCEL_W = (VEL_W+1)'(ACCEL);
   localparam logic signed [VEL_W:0] ONE_W   = (VEL_W+1)'(1);
   localparam logic signed [X_W:0]   X_LO    = (X_W+1)'(XMIN);
   localparam logic signed [X_W:0]   X_HI    = (X_W+1)'(XMAX);
   localparam logic signed [Y_W:0]   Y_LO    = (Y_W+1)'(YMIN);
   localparam logic signed [Y_W:0]   Y_HI    = (Y_W+1)'(YMAX);

   state_t                  state, state_nxt;
   logic [CNT_W-1:0]        wait_cnt;
   logic signed [VEL_W-1:0] vnew_x, vnew_y;
   logic                    wall_x, wall_y, blk_x_q, blk_y_q;
   logic signed [X_W:0]     nx;
   logic signed [Y_W:0]     ny;
   logic [X_W-1:0]          cx;
   logic [Y_W-1:0]          cy;
   logic                    wall_x_c, wall_y_c, timeout;

   // Accelerate on exactly one direction bit (saturating), otherwise decay one step toward zero.
   function automatic logic signed [VEL_W-1:0] next_vel(input logic signed [VEL_W-1:0] v,
                                                        input logic dec, input logic inc);
      logic signed [VEL_W:0] w;
      w = {v[VEL_W-1], v};
      if (dec ^ inc) begin
         w = inc ? w + ACCEL_W : w - ACCEL_W;
         if (w > VMAX_W)       w = VMAX_W;
         else if (w < -VMAX_W) w = -VMAX_W;
      end else if (w[VEL_W])   w = w + ONE_W;
      else if (w != '0)        w = w - ONE_W;
      return w[VEL_W-1:0];
   endfunction

`ifdef BALL_BOUNCE_EN
   // Reverse and halve, rounding the magnitude down so that +/-1 settles to 0.
   function automatic logic signed [VEL_W-1:0] bounce_vel(input logic signed [VEL_W-1:0] v);
      logic signed [VEL_W-1:0] mag;
      mag = v[VEL_W-1] ? -v : v;
      mag = mag >>> 1;
      return v[VEL_W-1] ? mag : -mag;
   endfunction
`endif

   assign busy    = (state != IDLE);
   assign timeout = (wait_cnt == CNT_W'(ACK_TIMEOUT - 1));

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      nx       = $signed({1'b0, pos_x}) + (X_W+1)'(vnew_x);
      ny       = $signed({1'b0, pos_y}) + (Y_W+1)'(vnew_y);
      cx       = nx[X_W-1:0];
      cy       = ny[Y_W-1:0];
      wall_x_c = 1'b0;
      wall_y_c = 1'b0;
      if (nx < X_LO)      begin cx = X_LO[X_W-1:0]; wall_x_c = 1'b1; end
      else if (nx > X_HI) begin cx = X_HI[X_W-1:0]; wall_x_c = 1'b1; end
      if (ny < Y_LO)      begin cy = Y_LO[Y_W-1:0]; wall_y_c = 1'b1; end
      else if (ny > Y_HI) begin cy = Y_HI[Y_W-1:0]; wall_y_c = 1'b1; end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (frame_tick) state_nxt = SAMPLE;
         SAMPLE:  state_nxt = PROPOSE;
         PROPOSE: state_nxt = WAIT;
         WAIT:    if (chk_ack || timeout) state_nxt = COMMIT;
         COMMIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         chk_req  <= 1'b0;
         chk_x    <= X_W'(START_X);
         chk_y    <= Y_W'(START_Y);
         pos_x    <= X_W'(START_X);
         pos_y    <= Y_W'(START_Y);
         vel_x    <= '0;
         vel_y    <= '0;
         vnew_x   <= '0;
         vnew_y   <= '0;
         wall_x   <= 1'b0;
         wall_y   <= 1'b0;
         blk_x_q  <= 1'b0;
         blk_y_q  <= 1'b0;
         wait_cnt <= '0;
         upd_done <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         upd_done <= 1'b0;
         if (frame_tick && state != IDLE) overrun <= 1'b1;
         case (state)
            SAMPLE: begin
               vnew_x <= next_vel(vel_x, tilt[0], tilt[1]);
               vnew_y <= next_vel(vel_y, tilt[2], tilt[3]);
            end
            PROPOSE: begin
               chk_x    <= cx;
               chk_y    <= cy;
               wall_x   <= wall_x_c;
               wall_y   <= wall_y_c;
               chk_req  <= 1'b1;
               wait_cnt <= '0;
            end
            WAIT: begin
               if (chk_ack) begin
                  blk_x_q <= blk_x;
                  blk_y_q <= blk_y;
                  chk_req <= 1'b0;
               end else if (timeout) begin
                  blk_x_q <= 1'b1;
                  blk_y_q <= 1'b1;
                  chk_req <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            COMMIT: begin
               // chk_x/chk_y already hold the wall-clamped proposal.
               if (!blk_x_q) pos_x <= chk_x;
               if (!blk_y_q) pos_y <= chk_y;
`ifdef BALL_BOUNCE_EN
               vel_x <= (blk_x_q || wall_x) ? bounce_vel(vnew_x) : vnew_x;
               vel_y <= (blk_y_q || wall_y) ? bounce_vel(vnew_y) : vnew_y;
`else
               vel_x <= (blk_x_q || wall_x) ? '0 : vnew_x;
               vel_y <= (blk_y_q || wall_y) ? '0 : vnew_y;
`endif
               upd_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed self-checking bench for ball_motion_ctrl; expected values are hand-computed constants.
// Expected velocities after a wall hit or block depend on BALL_BOUNCE_EN.
module tb_ball_motion_ctrl;

   logic              clk = 1'b0;
   logic              reset;
   logic              frame_tick;
   logic [3:0]        tilt;
   logic              chk_req;
   logic [9:0]        chk_x;
   logic [8:0]        chk_y;
   logic              chk_ack;
   logic              blk_x;
   logic              blk_y;
   logic [9:0]        pos_x;
   logic [8:0]        pos_y;
   logic signed [4:0] vel_x;
   logic signed [4:0] vel_y;
   logic              busy;
   logic              upd_done;
   logic              overrun;

   int n_checks = 0;
   int n_errors = 0;

`ifdef BALL_BOUNCE_EN
   localparam int WALL_VX = -4;
   localparam int TO_VX   = -1;
`else
   localparam int WALL_VX = 0;
   localparam int TO_VX   = 0;
`endif

   ball_motion_ctrl dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .tilt(tilt),
      .chk_req(chk_req), .chk_x(chk_x), .chk_y(chk_y), .chk_ack(chk_ack),
      .blk_x(blk_x), .blk_y(blk_y), .pos_x(pos_x), .pos_y(pos_y),
      .vel_x(vel_x), .vel_y(vel_y), .busy(busy), .upd_done(upd_done), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   // One frame: tick, latency checks, checker response (ack_dly<0 means never ack), commit checks.
   task automatic run_frame(input logic [3:0] t, input int ack_dly, input logic bx, input logic by,
                            input int ecx, input int ecy, input int epx, input int epy,
                            input int evx, input int evy);
      int held;
      tilt = t;
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      check("busy_sample", busy, 1);
      step();
      check("req_early", chk_req, 0);
      tilt = ~t;
      step();
      check("req_rise", chk_req, 1);
      check("chk_x", chk_x, ecx);
      check("chk_y", chk_y, ecy);
      if (ack_dly < 0) begin
         held = 0;
         for (int i = 0; i < 15; i++) begin
            step();
            if (chk_req) held++;
         end
         check("req_held", held, 15);
         step();
         check("req_timeout_drop", chk_req, 0);
      end else begin
         for (int i = 1; i < ack_dly; i++) step();
         chk_ack = 1'b1;
         blk_x = bx;
         blk_y = by;
         step();
         chk_ack = 1'b0;
         blk_x = 1'b0;
         blk_y = 1'b0;
         check("req_drop", chk_req, 0);
      end
      step();
      check("upd_done", upd_done, 1);
      check("pos_x", pos_x, epx);
      check("pos_y", pos_y, epy);
      check("vel_x", vel_x, evx);
      check("vel_y", vel_y, evy);
      step();
      check("upd_pulse", upd_done, 0);
      check("busy_idle", busy, 0);
   endtask

   int ramp_v[15] = '{1, 2, 3, 4, 5, 6, 7, 8, 8, 8, 8, 8, 8, 8, 8};
   int ramp_p[15] = '{321, 323, 326, 330, 335, 341, 348, 356, 364, 372, 380, 388, 396, 404, 412};
   int fric_v[3]  = '{7, 6, 5};
   int fric_p[3]  = '{419, 425, 430};

   initial begin
      reset = 1'b1;
      frame_tick = 1'b0;
      tilt = 4'b0000;
      chk_ack = 1'b0;
      blk_x = 1'b0;
      blk_y = 1'b0;
      #1;
      check("rst_pos_x", pos_x, 320);
      check("rst_pos_y", pos_y, 240);
      check("rst_vel_x", vel_x, 0);
      check("rst_vel_y", vel_y, 0);
      check("rst_req", chk_req, 0);
      check("rst_chk_x", chk_x, 320);
      check("rst_chk_y", chk_y, 240);
      check("rst_busy", busy, 0);
      check("rst_upd", upd_done, 0);
      check("rst_overrun", overrun, 0);
      step();
      reset = 1'b0;
      step();

      // Acceleration to saturation, then friction.
      for (int i = 0; i < 15; i++)
         run_frame(4'b0010, 1, 1'b0, 1'b0, ramp_p[i], 240, ramp_p[i], 240, ramp_v[i], 0);
      for (int i = 0; i < 3; i++)
         run_frame(4'b0000, 1, 1'b0, 1'b0, fric_p[i], 240, fric_p[i], 240, fric_v[i], 0);
      check("overrun_clean", overrun, 0);

      // chk_ack while idle must not start or commit anything.
      chk_ack = 1'b1;
      blk_x = 1'b1;
      blk_y = 1'b1;
      step();
      step();
      chk_ack = 1'b0;
      blk_x = 1'b0;
      blk_y = 1'b0;
      check("stray_ack_busy", busy, 0);
      check("stray_ack_upd", upd_done, 0);
      check("stray_ack_pos", pos_x, 430);

      // Ramp to x=636 at v=8, then hit the right wall.
      do_reset();
      for (int i = 0; i < 8; i++)
         run_frame(4'b0010, 1, 1'b0, 1'b0, ramp_p[i], 240, ramp_p[i], 240, ramp_v[i], 0);
      for (int k = 1; k <= 35; k++)
         run_frame(4'b0010, 2, 1'b0, 1'b0, 356 + 8*k, 240, 356 + 8*k, 240, 8, 0);
      run_frame(4'b0010, 1, 1'b0, 1'b0, 639, 240, 639, 240, WALL_VX, 0);

      // y move blocked by the checker while x moves freely.
      do_reset();
      run_frame(4'b1010, 1, 1'b0, 1'b1, 321, 241, 321, 240, 1, 0);

      // Checker never answers: forced block on both axes.
      run_frame(4'b0010, -1, 1'b0, 1'b0, 323, 240, 321, 240, TO_VX, 0);

      // Second tick while waiting: ignored, overrun sticky.
      tilt = 4'b0000;
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
      step();
      check("ovr_req", chk_req, 1);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      check("ovr_set", overrun, 1);
      check("ovr_still_wait", chk_req, 1);
      chk_ack = 1'b1;
      step();
      chk_ack = 1'b0;
      step();
      check("ovr_commit", upd_done, 1);
      check("ovr_pos_x", pos_x, 321);
      step();
      step();
      check("ovr_no_restart", busy, 0);
      check("ovr_sticky", overrun, 1);

      // Reset during WAIT takes effect without a clock edge.
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
      step();
      check("mid_req", chk_req, 1);
      reset = 1'b1;
      #1;
      check("mid_rst_req", chk_req, 0);
      check("mid_rst_pos_x", pos_x, 320);
      check("mid_rst_pos_y", pos_y, 240);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_overrun", overrun, 0);
      step();
      reset = 1'b0;
      step();
      check("post_rst_idle", busy, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
